// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core RAM arbiter: RAM word, RAM status and
// arbiter state encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int         NREQ       = 4;
    // Last-served value after reset, chosen so that requester 0 wins first.
    localparam logic [1:0] RESET_LAST = 2'd3;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick over four requesters, searching upward
// from the requester after the one served last.
module rr_select
    import cpu_types_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [1:0] cand_s;

    // Walk offsets 4..1 so the smallest offset that hits overwrites the rest.
    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        cand_s = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand_s = last + k[1:0];
            valid  = valid | req[cand_s];
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two cores' instruction and data caches shared
// access to a single RAM port.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CPUS-1:0] iREN,
    input  word_t           iaddr  [CPUS],
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    input  word_t           ramload,
    input  ramstate_t       ramstate,
    output logic [CPUS-1:0] iwait,
    output logic [CPUS-1:0] dwait,
    output word_t           iload  [CPUS],
    output word_t           dload  [CPUS],
    output word_t           ramaddr,
    output word_t           ramstore,
    output logic            ramREN,
    output logic            ramWEN
);

    arb_state_t      state_r, next_state_s;
    logic [1:0]      grant_idx_r, next_grant_s;
    logic [1:0]      last_idx_r, next_last_s;
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] wait_s;
    logic            sel_valid_s;
    logic [1:0]      sel_idx_s;
    logic            g_core_s;
    logic            g_instr_s;

    // Requester order: dcache0, icache0, dcache1, icache1.
    always_comb begin
        req_s     = {iREN[1], dREN[1] | dWEN[1], iREN[0], dREN[0] | dWEN[0]};
        g_core_s  = grant_idx_r[1];
        g_instr_s = grant_idx_r[0];
    end

    rr_select u_rr_select (
        .req   (req_s),
        .last  (last_idx_r),
        .valid (sel_valid_s),
        .idx   (sel_idx_s)
    );

    // Next-state and RAM command; reset forces an idle bus in the same cycle.
    always_comb begin
        next_state_s = state_r;
        next_grant_s = grant_idx_r;
        next_last_s  = last_idx_r;
        wait_s       = 4'hF;
        ramaddr      = 32'h0000_0000;
        ramstore     = 32'h0000_0000;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        if (RST) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_valid_s) begin
                        next_grant_s = sel_idx_s;
                        next_state_s = GRANT;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                GRANT: begin
                    if (g_instr_s) begin
                        ramaddr = iaddr[g_core_s];
                        ramREN  = iREN[g_core_s];
                    end else begin
                        ramaddr  = daddr[g_core_s];
                        ramstore = dstore[g_core_s];
                        ramWEN   = dWEN[g_core_s];
                        ramREN   = dREN[g_core_s] & ~dWEN[g_core_s];
                    end
                    // A withdrawn request abandons the slot without completing.
                    if (!req_s[grant_idx_r]) begin
                        next_state_s = IDLE;
                    end else if (ramstate == ACCESS) begin
                        wait_s[grant_idx_r] = 1'b0;
                        next_last_s         = grant_idx_r;
                        next_state_s        = IDLE;
                    end else begin
                        next_state_s = GRANT;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Per-requester stalls and broadcast read data.
    always_comb begin
        dwait = {wait_s[2], wait_s[0]};
        iwait = {wait_s[3], wait_s[1]};
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            grant_idx_r <= 2'd0;
            last_idx_r  <= RESET_LAST;
        end else begin
            state_r     <= next_state_s;
            grant_idx_r <= next_grant_s;
            last_idx_r  <= next_last_s;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a transaction-level model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic [1:0] iREN, dREN, dWEN;
    word_t     iaddr [2];
    word_t     daddr [2];
    word_t     dstore [2];
    word_t     ramload;
    ramstate_t ramstate;
    logic [1:0] iwait, dwait;
    word_t     iload [2];
    word_t     dload [2];
    word_t     ramaddr, ramstore;
    logic      ramREN, ramWEN;

    ram_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] waits;  // {icache1, dcache1, icache0, dcache0}
        logic       ren;
        logic       wen;
        word_t      addr;
        word_t      store;
        word_t      load;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Transaction-level model: current owner (-1 none) and last served.
    int owner  = -1;
    int last   = 3;
    int served = -1;

    function automatic logic req_of(int r);
        return (r % 2 == 0) ? (dREN[r/2] | dWEN[r/2]) : iREN[r/2];
    endfunction

    // Predict this cycle's outputs from current inputs, queue them, advance.
    task automatic step();
        exp_t e;
        int   c;
        logic found;
        e = '{waits: 4'hF, ren: 1'b0, wen: 1'b0, addr: 32'h0, store: 32'h0, load: ramload};
        served = -1;
        if (RST) begin
            owner = -1;
            last  = 3;
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req_of((last + k) % 4)) begin
                    owner = (last + k) % 4;
                    found = 1'b1;
                end
            end
        end else begin
            c = owner / 2;
            if (owner % 2 == 0) begin
                e.addr  = daddr[c];
                e.store = dstore[c];
                e.wen   = dWEN[c];
                e.ren   = dREN[c] & ~dWEN[c];
            end else begin
                e.addr = iaddr[c];
                e.ren  = iREN[c];
            end
            if (!req_of(owner)) begin
                owner = -1;
            end else if (ramstate == ACCESS) begin
                e.waits[owner] = 1'b0;
                served = owner;
                last   = owner;
                owner  = -1;
            end
        end
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
        for (int c = 0; c < 2; c++) begin
            iaddr[c] = 32'h0; daddr[c] = 32'h0; dstore[c] = 32'h0;
        end
        ramstate = FREE;
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare at negedge.
    initial begin
        exp_t e, a;
        logic load_ok;
        forever begin
            @(negedge CLK);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{waits: {iwait[1], dwait[1], iwait[0], dwait[0]}, ren: ramREN, wen: ramWEN,
                      addr: ramaddr, store: ramstore, load: ramload};
                load_ok = (iload[0] === e.load) && (iload[1] === e.load) &&
                          (dload[0] === e.load) && (dload[1] === e.load);
                vectors++;
                if (a !== e || !load_ok) begin
                    miscompares++;
                    $display("FAIL cycle_%0d: got waits=%b ren=%b wen=%b addr=%h store=%h loads_ok=%b, expected waits=%b ren=%b wen=%b addr=%h store=%h",
                             cyc, a.waits, a.ren, a.wen, a.addr, a.store, load_ok,
                             e.waits, e.ren, e.wen, e.addr, e.store);
                end
            end
        end
    end

    logic [3:0] pending;
    int         kind [2];

    initial begin
        RST = 1'b1;
        ramload = 32'h0;
        clear_inputs();
        pending = 4'h0;
        @(posedge CLK);
        #1;
        step(); step();
        RST = 1'b0;

        // Single data read straight after reset.
        dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = ACCESS;
        step(); step();
        clear_inputs(); step();

        // All four held with RAM always ready: strict rotation.
        iREN = 2'b11; dREN = 2'b11; ramstate = ACCESS;
        iaddr[0] = 32'h1000; iaddr[1] = 32'h3000; daddr[0] = 32'h2000; daddr[1] = 32'h4000;
        repeat (11) step();
        clear_inputs(); step();

        // Write from core 1 stalled by BUSY.
        dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'hDEADBEEF; ramstate = BUSY;
        repeat (4) step();
        ramstate = ACCESS; step();
        clear_inputs(); step();

        // icache1 granted, then drops its request while RAM is busy.
        iREN[1] = 1'b1; iaddr[1] = 32'h80; ramstate = BUSY;
        step(); step();
        iREN[1] = 1'b0; step();
        iREN = 2'b11; dREN = 2'b11; ramstate = ACCESS;
        repeat (4) step();
        clear_inputs(); step();

        // Reset while a grant is about to complete.
        iREN[0] = 1'b1; iaddr[0] = 32'h500; ramstate = BUSY;
        step(); step();
        ramstate = ACCESS; RST = 1'b1; step();
        RST = 1'b0; dREN = 2'b11; iREN = 2'b11;
        repeat (3) step();
        clear_inputs(); step();

        // ERROR status held for five cycles during a grant.
        iREN[0] = 1'b1; iaddr[0] = 32'h600; ramstate = ERROR;
        repeat (6) step();
        ramstate = ACCESS; step();
        clear_inputs(); step();

        // Randomized traffic with persistent requests and occasional drops/resets.
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 4; r++) begin
                if (!pending[r] && $urandom_range(0, 3) == 0) begin
                    pending[r] = 1'b1;
                    if (r % 2 == 0) begin
                        daddr[r/2]  = $urandom();
                        dstore[r/2] = $urandom();
                        kind[r/2]   = $urandom_range(0, 2);
                    end else begin
                        iaddr[r/2] = $urandom();
                    end
                end else if (pending[r] && $urandom_range(0, 15) == 0) begin
                    pending[r] = 1'b0;
                end
            end
            for (int c = 0; c < 2; c++) begin
                iREN[c] = pending[2*c+1];
                dREN[c] = pending[2*c] && (kind[c] != 1);
                dWEN[c] = pending[2*c] && (kind[c] != 0);
            end
            case ($urandom_range(0, 7))
                0, 1, 2, 3: ramstate = ACCESS;
                4, 5:       ramstate = BUSY;
                6:          ramstate = FREE;
                default:    ramstate = ERROR;
            endcase
            ramload = $urandom();
            RST = ($urandom_range(0, 199) == 0);
            step();
            if (served >= 0) pending[served] = 1'b0;
        end

        RST = 1'b0;
        clear_inputs();
        repeat (3) @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: CPUS, 2, number of cores sharing RAM; only the value 2 is supported.
REQ-002 Port: CLK  in  1  system clock, all state updates on its rising edge.
REQ-003 Port: RST  in  1  reset, synchronous, active-high.
REQ-004 Ports: iREN  in  [CPUS-1:0]  instruction read request per core; iaddr  in  word_t[CPUS]  instruction address.
REQ-005 Ports: dREN, dWEN  in  [CPUS-1:0]  data read/write request per core; daddr, dstore  in  word_t[CPUS]  data address, store data.
REQ-006 Ports: ramload  in  word_t  RAM read data; ramstate  in  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).
REQ-007 Ports: iwait, dwait  out  [CPUS-1:0]  per-requester stall, low only in the completion cycle.
REQ-008 Ports: iload, dload  out  word_t[CPUS]  all four driven with ramload.
REQ-009 Ports: ramaddr, ramstore  out  word_t; ramREN, ramWEN  out  1  RAM command for the granted requester.

Function
REQ-010 Requester index: 0=dcache0, 1=icache0, 2=dcache1, 3=icache1; request asserted = dREN|dWEN (data) or iREN (instr).
REQ-011 FSM states: IDLE, GRANT; register grant_idx (2 bits) and last_idx (2 bits).
REQ-012 IDLE: if any request, select first asserted index searching last_idx+1, +2, +3, +4 (mod 4); register it in grant_idx; go GRANT next edge.
REQ-013 IDLE with no request: remain IDLE; ramREN=ramWEN=0; ramaddr, ramstore=0.
REQ-014 GRANT: ramaddr=granted address; ramstore=granted dstore (data requesters), else 0.
REQ-015 GRANT: ramWEN=dWEN of grantee; ramREN=(dREN or iREN of grantee) & !ramWEN; never both high.
REQ-016 GRANT, ramstate==ACCESS: grantee's wait low this cycle; last_idx<=grant_idx; go IDLE.
REQ-017 GRANT, ramstate BUSY, FREE or ERROR: all waits high; stay GRANT.
REQ-018 GRANT, grantee's request deasserted: go IDLE next edge, last_idx unchanged, no wait low.
REQ-019 All non-granted waits high in every cycle; in IDLE all waits high.
REQ-020 Minimum service latency: request in IDLE cycle n, RAM command from cycle n+1, earliest wait low cycle n+1 (if ACCESS).
REQ-021 Simultaneous requests: strict round-robin per REQ-012; a continuously asserted requester is served within 4 grants.
REQ-022 Same-core dREN|dWEN and iREN both asserted: treated as two independent requesters.

Reset
REQ-023 RST high at rising edge: state<=IDLE, grant_idx<=0, last_idx<=3 (so index 0 wins first).
REQ-024 During and after reset: all waits high, ramREN=ramWEN=0, ramaddr=ramstore=0; reset mid-GRANT aborts the transfer with no wait low.

Structure
REQ-025 ramstate_t, word_t and the arbiter state enum belong in cpu_types_pkg.
REQ-026 Round-robin selection is one sub-module rr_select (4-bit request, 2-bit last, outputs valid and 2-bit index), purely combinational.

Verification
REQ-027 Reset then dREN[0]=1, daddr[0]=0x100, ramstate ACCESS -> ramREN=1, ramaddr=0x100 cycle 1, dwait[0]=0 cycle 1, others 1.
REQ-028 All four requests held, RAM always ACCESS -> grants in order 0,1,2,3,0 at one completion per 2 cycles.
REQ-029 dWEN[1]=1, daddr[1]=0x40, dstore[1]=0xDEADBEEF, ramstate BUSY 3 cycles then ACCESS -> ramWEN=1, ramstore=0xDEADBEEF held; dwait[1] low only in ACCESS cycle.
REQ-030 Grantee iREN[1] dropped while ramstate BUSY -> IDLE next edge, iwait[1] never low, next grant still index 2 or later.
REQ-031 RST asserted in GRANT with ramstate ACCESS -> no wait low, next cycle IDLE, last_idx=3.
REQ-032 ramstate ERROR held 5 cycles in GRANT -> waits high throughout, ramREN held, completes on later ACCESS.
